ser16_tx: RTL
=============

# ser16_tx

Parallel-to-serial transmitter for 16-bit words. It captures a word through a valid/ready handshake. A 4-bit bit counter then steps a 16:1 multiplexer select across the held word, so one bit is presented per clock. It sits directly upstream of the serial link and drives the select of its bit-selection multiplexer; it is the sequencer that feeds that mux.

## Interface
Parameters:
- `MSB_FIRST`, default 0: 0 sends bit 0 first; 1 sends bit 15 first.
- `IDLE_LEVEL`, default 1'b0: level driven on `sout` when no bit is valid.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: `in_data` holds a word to send.
- `in_ready`, output, 1: the block accepts the word this cycle.
- `in_data`, input, 16: parallel word.
- `sout`, output, 1: serial bit.
- `sout_valid`, output, 1: `sout` carries a frame bit this cycle.
- `sout_first`, output, 1: first bit of a frame.
- `sout_last`, output, 1: last bit of a frame.
- `busy`, output, 1: a frame is in progress (equals `sout_valid`).

## Operation
- Transfer occurs when `in_valid && in_ready` at a rising edge. `in_data` is latched into the 16-bit `hold` register and `cnt` is cleared to 0.
- States:
  - IDLE: `in_ready`=1, `sout_valid`=0, `sout`=`IDLE_LEVEL`. On transfer go to SHIFT; otherwise stay in IDLE.
  - SHIFT: `sout_valid`=1. Mux select is `cnt` if `MSB_FIRST`=0, else `~cnt`; `sout` = `hold[select]`. `cnt` increments every cycle.
  - Leaving SHIFT at `cnt`==15: go to PARITY if the parity feature is compiled in; else go to SHIFT on a transfer that same cycle, else IDLE.
  - PARITY (feature only): `sout` = stored parity bit, `sout_valid`=1, `sout_last`=1. Go to SHIFT on a transfer that same cycle, else IDLE.
- `in_ready` is 1 in IDLE and in the last-bit cycle of a frame. The last-bit cycle is SHIFT with `cnt`==15 without the feature, or PARITY with it. Everywhere else `in_ready` is 0.
  - A transfer in the last-bit cycle reloads `hold`, clears `cnt`, and starts the next frame with no gap cycle.
- `sout_first` = 1 when in SHIFT with `cnt`==0.
- `sout_last` = 1 in SHIFT with `cnt`==15 without the feature; with the feature it is 1 only in PARITY.
- `in_data` is sampled only at a transfer. Changes to `in_data` mid-frame have no effect.
- `cnt` is 4 bits and wraps 15→0 only through the reload or IDLE paths. It is never free-running in IDLE; it holds 0 there.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system) forces:
  - state IDLE; `cnt`=0; `hold`=0; parity=0.
  - `in_ready`=1; `sout_valid`=0; `sout_first`=0; `sout_last`=0; `busy`=0; `sout`=`IDLE_LEVEL`.
- Reset mid-frame aborts the frame immediately; no partial-frame completion.
- Latency: transfer at edge N puts the first bit on `sout` in cycle N+1. The frame occupies 16 cycles (17 with parity).
- All outputs are decoded from registered state, `cnt`, and `hold` only. There is no combinational path from `in_valid`/`in_data` to any output, including `in_ready`.
- Sustained throughput: one word per 16 cycles (per 17 with parity).

## Configuration
- Macro: `SER16_TX_PARITY_EN`.
- Defined: at transfer, the even-parity bit `^in_data` is stored. PARITY adds one trailing bit to every frame, giving a 17-bit frame.
- Undefined: there is no PARITY state, no parity register, and the frame is 16 bits; `sout_last` marks bit 15 of the transmission order.

## Structure
- Shared package `ser16_pkg`:
  - state encoding: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2.
  - constants `SER16_W`=16 and `SER16_CNT_W`=4.
- Sub-module: the team's existing `mux16_1` (16-bit `In`, 4-bit `S`, 1-bit `Out`), instanced once.
  - `In`=`hold`, `S`=computed select.
  - Its output is gated to `IDLE_LEVEL` when not in SHIFT and replaced by parity in PARITY.
- Control FSM, counter, and handshake logic stay in `ser16_tx`.

## Test plan
- LSB-first: reset, send `in_data`=16'hA5C3 → `sout` over cycles N+1..N+16 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; `sout_first` only at N+1; `sout_last` only at N+16.
- MSB-first (`MSB_FIRST`=1), send 16'h8001 → first bit 1, then fourteen 0s, then 1; `in_ready`=0 during cycles N+1..N+15.
- Back-to-back: `in_valid` held high with 16'hFFFF then 16'h0000 → 32 contiguous valid bits; `sout_valid` never drops; second word is accepted exactly in the last-bit cycle.
- Idle / backpressure: `in_valid`=0 for 10 cycles after a frame → `sout`=`IDLE_LEVEL`, `busy`=0, `in_ready`=1 throughout.
- Reset mid-frame: assert `rst_n`=0 asynchronously at bit 7 of 16'h1234 → all outputs take reset values before the next edge; after release the next word starts cleanly at bit 0.
- Parity (`SER16_TX_PARITY_EN`): 16'h0007 → 17th bit = 1 with `sout_last`=1; 16'h0003 → 17th bit = 0.

Source files
------------

// File: rtl/ser16_pkg.sv
// Shared definitions for the ser16 serial transmitter: FSM state encoding
// and word/counter widths.
package ser16_pkg;

    localparam int SER16_W     = 16;
    localparam int SER16_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser16_state_e;

endpackage

// File: rtl/mux16_1.sv
// 16:1 single-bit multiplexer: Out = In[S].
module mux16_1 (
    input  logic [15:0] In,
    input  logic [3:0]  S,
    output logic        Out
);

    // Pure bit selection; the caller owns gating and sequencing.
    always_comb begin
        Out = In[S];
    end

endmodule

// File: rtl/ser16_tx.sv
// ser16_tx: 16-bit parallel-to-serial transmitter with a valid/ready input.
// A 4-bit counter walks the mux16_1 select across the captured word, one bit
// per clock. Build option SER16_TX_PARITY_EN appends an even-parity bit,
// making each frame 17 bits. All outputs decode from registered state only.
module ser16_tx
    import ser16_pkg::*;
#(
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SER16_W-1:0] in_data,
    output logic               sout,
    output logic               sout_valid,
    output logic               sout_first,
    output logic               sout_last,
    output logic               busy
);

    localparam logic [SER16_CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [SER16_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [SER16_CNT_W-1:0] CNT_ONE  = {{(SER16_CNT_W-1){1'b0}}, 1'b1};

    ser16_state_e             state_q;
    ser16_state_e             state_d;
    logic [SER16_CNT_W-1:0]   cnt_q;
    logic [SER16_W-1:0]       hold_q;
    logic [SER16_CNT_W-1:0]   sel;
    logic                     mux_bit;
    logic                     last_bit;
    logic                     xfer;
    logic                     par_bit;

`ifdef SER16_TX_PARITY_EN
    logic                     par_q;
`endif

    // Last-bit cycle of a frame: the only non-idle cycle that may accept a word.
    always_comb begin
`ifdef SER16_TX_PARITY_EN
        last_bit = (state_q == ST_PARITY);
        par_bit  = par_q;
`else
        last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_MAX);
        par_bit  = 1'b0;
`endif
        in_ready = (state_q == ST_IDLE) || last_bit;
        xfer     = in_valid && in_ready;
    end

    // Next-state logic; a transfer in the last-bit cycle chains frames gap-free.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_MAX) begin
`ifdef SER16_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = xfer ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef SER16_TX_PARITY_EN
            ST_PARITY: begin
                state_d = xfer ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Word capture and bit counter; counter only advances while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            hold_q <= '0;
        end else if (xfer) begin
            cnt_q  <= CNT_ZERO;
            hold_q <= in_data;
        end else if (state_q == ST_SHIFT) begin
            cnt_q  <= cnt_q + CNT_ONE;
        end
    end

`ifdef SER16_TX_PARITY_EN
    // Even parity of the accepted word, sent as the trailing frame bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    par_q <= 1'b0;
        else if (xfer) par_q <= ^in_data;
    end
`endif

    assign sel = (MSB_FIRST != 0) ? ~cnt_q : cnt_q;

    mux16_1 u_mux (
        .In  (hold_q),
        .S   (sel),
        .Out (mux_bit)
    );

    // Serial output decode: mux bit while shifting, parity bit, else idle level.
    always_comb begin
        sout       = IDLE_LEVEL;
        sout_valid = (state_q != ST_IDLE);
        sout_first = (state_q == ST_SHIFT) && (cnt_q == CNT_ZERO);
        sout_last  = last_bit;
        busy       = sout_valid;
        if (state_q == ST_SHIFT)       sout = mux_bit;
        else if (state_q == ST_PARITY) sout = par_bit;
    end

endmodule
